// File: rtl/pcreg_pkg.sv
// pcreg_pkg: CPU-wide program-counter width and reset vector
package pcreg_pkg;
   localparam int PC_WIDTH = 32;
   localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
endpackage

// File: rtl/pcreg_dffe.sv
// pcreg_dffe: 1-bit D flip-flop with synchronous active-high reset and load enable
// clk: clock, rst: sync reset to RST_VAL, ena: load enable, d: next bit, q: stored bit
import pcreg_pkg::*;
module pcreg_dffe #(
   parameter logic RST_VAL = RESET_VECTOR[0]
) (
   input  logic clk,
   input  logic rst,
   input  logic ena,
   input  logic d,
   output logic q
);
   logic q_q, q_d;
   always_comb q_d = rst ? RST_VAL : ena ? d : q_q;
   always_ff @(posedge clk) q_q <= q_d;
   assign q = q_q;
endmodule

// File: rtl/pcreg.sv
// pcreg: WIDTH-bit program-counter register built from per-bit enabled flops
// clk: clock, rst: sync reset to RESET_VALUE, ena: load enable,
// data_in: next PC, data_out: current PC (registered)
import pcreg_pkg::*;
module pcreg #(
   parameter int WIDTH = PC_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(RESET_VECTOR)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out
);
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      pcreg_dffe #(.RST_VAL(RESET_VALUE[i])) u_dffe (
         .clk(clk),
         .rst(rst),
         .ena(ena),
         .d  (data_in[i]),
         .q  (data_out[i])
      );
   end
endmodule

// File: tb/tb_pcreg.sv
// tb_pcreg: directed self-checking bench for pcreg
module tb_pcreg;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ena = 1'b0;
   logic [31:0] data_in = '0;
   logic [31:0] data_out;
   int checks = 0;
   int errors = 0;
   pcreg dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .data_in (data_in),
      .data_out(data_out)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic check(input string tag, input logic [31:0] exp);
      checks++;
      assert (data_out === exp)
      else begin
         errors++;
         $error("FAIL %s: data_out=%h expected %h", tag, data_out, exp);
      end
   endtask
   initial begin
      #1;
      rst = 1'b0; ena = 1'b0; data_in = 32'd19430407;
      tick();
      checks++;
      assert (data_out !== 32'd19430407)
      else begin
         errors++;
         $error("FAIL hold_pre_reset: data_out=%h expected not %h", data_out, 32'd19430407);
      end
      rst = 1'b1;
      tick();
      check("reset", 32'h0000_0000);
      rst = 1'b0; ena = 1'b1; data_in = 32'h0128_7C07;
      tick();
      check("load_after_reset", 32'h0128_7C07);
      rst = 1'b1; ena = 1'b1; data_in = 32'hFFFF_FFFF;
      tick();
      check("reset_priority", 32'h0000_0000);
      rst = 1'b0; ena = 1'b1; data_in = 32'h0040_0000;
      tick();
      check("load_0040", 32'h0040_0000);
      rst = 1'b1; ena = 1'b0;
      #2;
      check("rst_mid_cycle", 32'h0040_0000);
      tick();
      check("rst_at_edge", 32'h0000_0000);
      rst = 1'b0; ena = 1'b1; data_in = 32'h0040_0000;
      tick();
      check("reload_0040", 32'h0040_0000);
      ena = 1'b0; data_in = 32'h1234_5678;
      tick();
      check("hold_1", 32'h0040_0000);
      tick();
      check("hold_2", 32'h0040_0000);
      tick();
      check("hold_3", 32'h0040_0000);
      ena = 1'b1; data_in = 32'hDEAD_BEEF;
      #2;
      check("ena_mid_cycle", 32'h0040_0000);
      data_in = 32'hFFFF_FFFF;
      tick();
      check("full_ones", 32'hFFFF_FFFF);
      data_in = 32'h8000_0001;
      tick();
      check("msb_lsb", 32'h8000_0001);
      data_in = 32'h7FFF_FFFE;
      tick();
      check("inverse_msb_lsb", 32'h7FFF_FFFE);
      rst = 1'b1;
      tick();
      check("reset_again", 32'h0000_0000);
      rst = 1'b0; ena = 1'b1; data_in = 32'hA5A5_5A5A;
      tick();
      check("release_load", 32'hA5A5_5A5A);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
